// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic family (subtractor now,
// adder and comparator later): FSM state encoding and default operand width.
package serial_arith_pkg;

   localparam int SERIAL_DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } serial_state_e;

endpackage

// File: rtl/full_subtractor_1bit.sv
// Single-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor_1bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_32bits_subtractor.sv
// Bit-serial A - B - Bin engine, one bit per clock, LSB first, using one
// full-subtractor cell and a borrow flop. Start/ready/done handshake; Diff and
// Bout are held until the next operation completes.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds the signed-overflow output Ovf.
module serial_32bits_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = SERIAL_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             Ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   serial_state_e    state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-2:0] res;
   logic             borrow;
   logic [CW-1:0]    cnt;

   logic             d_c;
   logic             bout_c;
   logic [WIDTH-1:0] shift_next;

`ifdef SERIAL_SUB_OVERFLOW_EN
   // Operand sign bits are shifted away during SHIFT, so keep them aside.
   logic             a_msb;
   logic             b_msb;
`endif

   full_subtractor_1bit u_cell (
      .a    (ra[0]),
      .b    (rb[0]),
      .bin  (borrow),
      .d    (d_c),
      .bout (bout_c)
   );

   // New bit enters at the MSB; on the last step this is the complete result.
   assign shift_next = {d_c, res};

   // Handshake FSM with the serial datapath; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ready  <= 1'b1;
         done   <= 1'b0;
         Diff   <= '0;
         Bout   <= 1'b0;
         ra     <= '0;
         rb     <= '0;
         res    <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         Ovf    <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  ra     <= A;
                  rb     <= B;
                  borrow <= Bin;
                  cnt    <= '0;
                  ready  <= 1'b0;
                  state  <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  a_msb  <= A[WIDTH-1];
                  b_msb  <= B[WIDTH-1];
`endif
               end
            end
            SHIFT: begin
               ra     <= ra >> 1;
               rb     <= rb >> 1;
               borrow <= bout_c;
               res    <= shift_next[WIDTH-1:1];
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  Diff  <= shift_next;
                  Bout  <= bout_c;
                  done  <= 1'b1;
                  state <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  // Signs differ and the result sign departs from the minuend.
                  Ovf   <= (a_msb ^ b_msb) & (d_c ^ a_msb);
`endif
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
